pool_flatten_ctrl: RTL
======================

POOL_FLATTEN_CTRL -- requirements
Module: pool_flatten_ctrl

Interface
REQ-001 Parameter: DW, 20, data word width (4.16 signed fixed point).
REQ-002 Parameter: IMG_W, 64, layer-0 map width and height in pixels; the pooled map is IMG_W/2 square.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  reset, synchronous and active-high.
REQ-005 Port: start  in  1  one-cycle request to run max-pool plus flatten; sampled only in IDLE.
REQ-006 Port: busy  out  1  high in every state except IDLE.
REQ-007 Port: done  out  1  one-cycle pulse when the last L2 word is written.
REQ-008 Port: crd  out  1  layer-memory read strobe.
REQ-009 Port: caddr_rd  out  12  layer-memory read address.
REQ-010 Port: cdata_rd  in  DW  read data, valid at the rising edge ending the crd cycle.
REQ-011 Port: cwr  out  1  layer-memory write strobe, written at the rising edge ending the cwr cycle.
REQ-012 Port: caddr_wr  out  12  layer-memory write address.
REQ-013 Port: cdata_wr  out  DW  write data.
REQ-014 Port: csel  out  3  memory select: 001=L0K0, 010=L0K1, 011=L1K0, 100=L1K1, 101=L2, 000=none.

Function
REQ-015 States: IDLE, RD0, RD1, RD2, RD3, WR1, WR2, DONE; outputs are a Moore decode of state, kernel bit k, row r (5b) and column c (5b).
REQ-016 IDLE plus start moves to RD0 with k=0, r=0, c=0; start in any other state is ignored.
REQ-017 RDn asserts crd=1, cwr=0, csel=001+k; caddr_rd is 2r*IMG_W+2c for RD0, +1 for RD1, +IMG_W for RD2, and +IMG_W+1 for RD3.
REQ-018 The edge leaving RD0 loads max<=cdata_rd; the edges leaving RD1-RD3 load max<=signed max(max, cdata_rd); ties keep max.
REQ-019 WR1 asserts cwr=1, crd=0, csel=011+k, caddr_wr=r*32+c, cdata_wr=max.
REQ-020 WR2 asserts cwr=1, crd=0, csel=101, caddr_wr=2*(r*32+c)+k, cdata_wr=max.
REQ-021 After WR2, c increments; when c wraps 31->0, r increments; when r wraps 31->0, k goes 0->1 and the next state is RD0; when k=1 wraps, the next state is DONE; otherwise the next state is RD0.
REQ-022 DONE asserts done=1 and busy=1 for exactly one cycle, then returns to IDLE.
REQ-023 crd and cwr are never high in the same cycle; csel=000 in IDLE and DONE.
REQ-024 Latency: 6 cycles per pooled word; 2*1024*6=12288 working cycles; done occurs in the 12289th cycle after the start edge.
REQ-025 In IDLE and DONE, the address and data outputs are 0.

Reset
REQ-026 With reset high at a rising edge, the next state is IDLE, with k, r, c and max cleared and pending start discarded.
REQ-027 During reset and the cycle after: busy=0, done=0, crd=0, cwr=0, csel=000, caddr_rd=0, caddr_wr=0, cdata_wr=0.
REQ-028 Reset mid-operation aborts without any further write; the next start restarts from k=0, r=0, c=0.
REQ-029 Reset has priority over start in the same cycle.

Verification
REQ-030 Reset held 2 cycles -> all outputs 0, busy=0; start held low 10 cycles -> outputs unchanged.
REQ-031 L0K0[0,1,64,65]=00010,00030,00020,00005 and start -> reads 0,1,64,65 with csel=001 in cycles 1-4; cycle 5 writes L1K0[0]=00030 with csel=011; cycle 6 writes L2[0]=00030 with csel=101.
REQ-032 Pooled index 33 (r=1, c=1) -> reads 130,131,194,195; L1 addr 33; L2 addr 66 for k=0 and 67 for k=1.
REQ-033 Random non-negative L0K0/L0K1 golden run -> L1K0, L1K1 and L2 match the model bit-exact; done in cycle 12289; busy high 12289 cycles; no cycle with crd&cwr.
REQ-034 Four equal inputs FFFF0 (negative) -> write FFFF0 (signed compare); inputs 7FFFF,80000 -> max 7FFFF.
REQ-035 Reset at cycle 500, then start at cycle 510 -> no write between 500 and 510; the first read after restart is addr 0 with csel=001; the full run completes correctly.

Source files
------------

// File: rtl/pool_flatten_ctrl.sv
// ---------------------------------------------------------------------------
// pool_flatten_ctrl
//
// Sequencer for the 2x2 max-pool + flatten stage. For each of the two
// kernels (k = 0, 1) it walks the pooled map (IMG_W/2 x IMG_W/2) in raster
// order. For each pooled word it reads the four layer-0 pixels of the 2x2
// window, keeps a running signed maximum, writes that maximum into the
// layer-1 map of the same kernel, and writes it again into the flattened
// layer-2 buffer. In layer 2 the two kernels are interleaved: kernel k of
// pooled index i lands at 2*i + k.
//
// Every pooled word takes six cycles: RD0..RD3, WR1, WR2. A pulse on done
// marks the end of the second kernel pass, one cycle after the last L2 write.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-high; clears state and masks outputs
//   start     : run request, only looked at in IDLE
//   busy      : high in every state except IDLE
//   done      : one-cycle completion pulse (DONE state)
//   crd       : layer-memory read strobe
//   caddr_rd  : layer-memory read address
//   cdata_rd  : read data, captured on the edge that ends the crd cycle
//   cwr       : layer-memory write strobe
//   caddr_wr  : layer-memory write address
//   cdata_wr  : write data (the current pooled maximum)
//   csel      : memory select 001=L0K0 010=L0K1 011=L1K0 100=L1K1 101=L2
// ---------------------------------------------------------------------------
module pool_flatten_ctrl #(
    parameter int DW    = 20,
    parameter int IMG_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [11:0]   caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int AW = 12;
    localparam int PW = IMG_W / 2;       // pooled map width and height
    localparam int CW = $clog2(PW);      // row / column counter width

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L2   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_WR1,
        S_WR2,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic            k;
    logic [CW-1:0]   r, c;
    logic [DW-1:0]   max_q;

    logic            last_col, last_row;
    logic [31:0]     rd_base;            // top-left pixel of the 2x2 window
    logic [31:0]     pool_idx;           // raster index inside the pooled map
    logic [2:0]      k_sel;

    assign last_col = (c == CW'(PW - 1));
    assign last_row = (r == CW'(PW - 1));
    assign k_sel    = {2'b00, k};

    always_comb begin
        rd_base  = 32'(r) * 32'(2 * IMG_W) + 32'(c) * 32'd2;
        pool_idx = 32'(r) * 32'(PW) + 32'(c);
    end

    // ------------------------------------------------------------------
    // State, counters and running maximum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= 1'b0;
            r     <= '0;
            c     <= '0;
            max_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k <= 1'b0;
                        r <= '0;
                        c <= '0;
                    end
                end
                // First pixel of a window seeds the maximum unconditionally.
                S_RD0: max_q <= cdata_rd;
                // Strictly greater replaces; equal keeps the held value.
                S_RD1, S_RD2, S_RD3: begin
                    if ($signed(cdata_rd) > $signed(max_q))
                        max_q <= cdata_rd;
                end
                S_WR2: begin
                    c <= c + 1'b1;
                    if (last_col) begin
                        r <= r + 1'b1;
                        if (last_row)
                            k <= ~k;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RD0;
            S_RD0:   state_nx = S_RD1;
            S_RD1:   state_nx = S_RD2;
            S_RD2:   state_nx = S_RD3;
            S_RD3:   state_nx = S_WR1;
            S_WR1:   state_nx = S_WR2;
            S_WR2:   state_nx = (last_col && last_row && k) ? S_DONE : S_RD0;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode. While reset is asserted the outputs are forced
    // to their idle values so nothing leaks out during the reset cycle,
    // whatever the state register held before it.
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = SEL_NONE;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        if (!reset) begin
            busy = (state != S_IDLE);
            case (state)
                S_RD0: begin
                    crd      = 1'b1;
                    csel     = SEL_L0K0 + k_sel;
                    caddr_rd = AW'(rd_base);
                end
                S_RD1: begin
                    crd      = 1'b1;
                    csel     = SEL_L0K0 + k_sel;
                    caddr_rd = AW'(rd_base + 32'd1);
                end
                S_RD2: begin
                    crd      = 1'b1;
                    csel     = SEL_L0K0 + k_sel;
                    caddr_rd = AW'(rd_base + 32'(IMG_W));
                end
                S_RD3: begin
                    crd      = 1'b1;
                    csel     = SEL_L0K0 + k_sel;
                    caddr_rd = AW'(rd_base + 32'(IMG_W) + 32'd1);
                end
                S_WR1: begin
                    cwr      = 1'b1;
                    csel     = SEL_L1K0 + k_sel;
                    caddr_wr = AW'(pool_idx);
                    cdata_wr = max_q;
                end
                S_WR2: begin
                    // Flattened buffer interleaves the two kernels.
                    cwr      = 1'b1;
                    csel     = SEL_L2;
                    caddr_wr = AW'(pool_idx * 32'd2 + 32'(k));
                    cdata_wr = max_q;
                end
                S_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
